// File: rtl/screen_region_scanner.sv
// Rectangular framebuffer region scanner: read-modify-write of each pixel, 3 cycles per pixel.
// Optional macro SCREEN_SKIP_UNCHANGED_EN suppresses writes whose new colour equals the stored one.
module screen_region_scanner #(
    parameter int COLOUR_BITS = 3,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   screen_start,
    input  logic [7:0]             screen_x_min,
    input  logic [7:0]             screen_y_min,
    input  logic [7:0]             screen_x_range,
    input  logic [7:0]             screen_y_range,
    output logic [7:0]             screen_x,
    output logic [7:0]             screen_y,
    output logic [COLOUR_BITS-1:0] old_screen_colour,
    input  logic [COLOUR_BITS-1:0] new_screen_colour,
    output logic                   screen_done,
    output logic                   busy,
    output logic [7:0]             fb_x,
    output logic [6:0]             fb_y,
    input  logic [COLOUR_BITS-1:0] fb_rdata,
    output logic                   fb_we,
    output logic [COLOUR_BITS-1:0] fb_wdata
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        FETCH,
        WRITE,
        DONE
    } state_t;

    state_t     state;
    // Counters are 9 bits so regions running past column/row 255 do not wrap.
    logic [8:0] x_cnt;
    logic [8:0] y_cnt;
    logic [8:0] x_last;
    logic [8:0] y_last;
    logic [7:0] x_min_q;
    logic       last_col;
    logic       last_row;
    logic       in_bounds;
    logic       write_ok;

    assign last_col  = (x_cnt == x_last);
    assign last_row  = (y_cnt == y_last);
    assign in_bounds = (x_cnt < 9'(SCREEN_W)) && (y_cnt < 9'(SCREEN_H));

`ifdef SCREEN_SKIP_UNCHANGED_EN
    assign write_ok = in_bounds && (new_screen_colour != old_screen_colour);
`else
    assign write_ok = in_bounds;
`endif

    assign fb_we    = (state == WRITE) && write_ok;
    assign fb_wdata = (state == WRITE) ? new_screen_colour : '0;
    assign screen_x = x_cnt[7:0];
    assign screen_y = y_cnt[7:0];
    assign fb_x     = x_cnt[7:0];
    assign fb_y     = y_cnt[6:0];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state             <= IDLE;
            x_cnt             <= '0;
            y_cnt             <= '0;
            x_last            <= '0;
            y_last            <= '0;
            x_min_q           <= '0;
            old_screen_colour <= '0;
            busy              <= 1'b0;
            screen_done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    screen_done <= 1'b0;
                    if (screen_start) begin
                        x_min_q <= screen_x_min;
                        x_last  <= {1'b0, screen_x_min} + {1'b0, screen_x_range};
                        y_last  <= {1'b0, screen_y_min} + {1'b0, screen_y_range};
                        x_cnt   <= {1'b0, screen_x_min};
                        y_cnt   <= {1'b0, screen_y_min};
                        busy    <= 1'b1;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    state <= FETCH;
                end
                FETCH: begin
                    old_screen_colour <= fb_rdata;
                    state             <= WRITE;
                end
                WRITE: begin
                    if (!last_col) begin
                        x_cnt <= x_cnt + 9'd1;
                        state <= ADDR;
                    end else if (!last_row) begin
                        x_cnt <= {1'b0, x_min_q};
                        y_cnt <= y_cnt + 9'd1;
                        state <= ADDR;
                    end else begin
                        screen_done <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    screen_done <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    screen_done <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_screen_region_scanner.sv
// Randomised bench for screen_region_scanner against a loop-based region model and a behavioural framebuffer.
module tb_screen_region_scanner;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       screen_start = 1'b0;
    logic [7:0] screen_x_min = '0;
    logic [7:0] screen_y_min = '0;
    logic [7:0] screen_x_range = '0;
    logic [7:0] screen_y_range = '0;
    logic [7:0] screen_x;
    logic [7:0] screen_y;
    logic [2:0] old_screen_colour;
    logic [2:0] new_screen_colour;
    logic       screen_done;
    logic       busy;
    logic [7:0] fb_x;
    logic [6:0] fb_y;
    logic [2:0] fb_rdata = '0;
    logic       fb_we;
    logic [2:0] fb_wdata;

    logic       const_mode = 1'b0;
    logic [2:0] const_colour = '0;
    logic [2:0] mem [0:255][0:127];
    logic [23:0] got_q [$];
    logic [23:0] exp_q [$];
    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    screen_region_scanner #(
        .COLOUR_BITS(3),
        .SCREEN_W(160),
        .SCREEN_H(120)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .screen_start(screen_start),
        .screen_x_min(screen_x_min),
        .screen_y_min(screen_y_min),
        .screen_x_range(screen_x_range),
        .screen_y_range(screen_y_range),
        .screen_x(screen_x),
        .screen_y(screen_y),
        .old_screen_colour(old_screen_colour),
        .new_screen_colour(new_screen_colour),
        .screen_done(screen_done),
        .busy(busy),
        .fb_x(fb_x),
        .fb_y(fb_y),
        .fb_rdata(fb_rdata),
        .fb_we(fb_we),
        .fb_wdata(fb_wdata)
    );

    function automatic logic [2:0] colour_fn(input logic [7:0] x, input logic [7:0] y, input logic [2:0] old);
        logic [2:0] r;
        r = x[2:0] ^ {y[1:0], 1'b0};
        return r + old;
    endfunction

    assign new_screen_colour = const_mode ? const_colour : colour_fn(screen_x, screen_y, old_screen_colour);

    // Framebuffer: read data appears one cycle after the address, reads see pre-write contents.
    always @(posedge clock) begin
        fb_rdata <= mem[fb_x][fb_y];
        if (fb_we) mem[fb_x][fb_y] = fb_wdata;
    end

    always @(negedge clock) begin
        if (fb_we) got_q.push_back({fb_x, 1'b0, fb_y, 5'b0, fb_wdata});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic build_expected(input int xmin, input int ymin, input int xr, input int yr);
        logic [2:0] old;
        logic [2:0] nw;
        exp_q.delete();
        for (int y = ymin; y <= ymin + yr; y++) begin
            for (int x = xmin; x <= xmin + xr; x++) begin
                if (x < 160 && y < 120) begin
                    old = mem[x][y];
                    nw  = const_mode ? const_colour : colour_fn(8'(x), 8'(y), old);
`ifdef SCREEN_SKIP_UNCHANGED_EN
                    if (nw != old) exp_q.push_back({8'(x), 1'b0, 7'(y), 5'b0, nw});
`else
                    exp_q.push_back({8'(x), 1'b0, 7'(y), 5'b0, nw});
`endif
                end
            end
        end
    endtask

    // Call just after a negedge; poke_cycle>0 pulses a conflicting start mid-scan.
    task automatic run_scan(input int xmin, input int ymin, input int xr, input int yr, input int poke_cycle);
        int cyc;
        int lat;
        build_expected(xmin, ymin, xr, yr);
        got_q.delete();
        lat = 3 * (xr + 1) * (yr + 1) + 1;
        screen_x_min   = 8'(xmin);
        screen_y_min   = 8'(ymin);
        screen_x_range = 8'(xr);
        screen_y_range = 8'(yr);
        screen_start   = 1'b1;
        @(negedge clock);
        screen_start = 1'b0;
        cyc = 1;
        check_eq("busy_first", 32'(busy), 32'd1);
        while (!screen_done && cyc < lat + 10) begin
            if (cyc == poke_cycle) begin
                screen_x_min   = 8'(xmin + 37);
                screen_y_min   = 8'(ymin + 11);
                screen_x_range = 8'(xr + 2);
                screen_start   = 1'b1;
            end
            @(negedge clock);
            screen_start = 1'b0;
            cyc++;
        end
        check_eq("done_cycle", 32'(cyc), 32'(lat));
        check_eq("busy_done", 32'(busy), 32'd1);
        screen_start = 1'b1;
        @(negedge clock);
        screen_start = 1'b0;
        check_eq("done_width", 32'(screen_done), 32'd0);
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("n_writes", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_eq("write", 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int dones;
        for (int x = 0; x < 256; x++)
            for (int y = 0; y < 128; y++)
                mem[x][y] = 3'($urandom_range(0, 7));

        @(negedge clock);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(screen_done), 32'd0);
        check_eq("rst_we", 32'(fb_we), 32'd0);
        check_eq("rst_xy", {16'(screen_x), 16'(screen_y)}, 32'd0);
        check_eq("rst_fbxy", {16'(fb_x), 16'(fb_y)}, 32'd0);
        check_eq("rst_colours", {16'(old_screen_colour), 16'(fb_wdata)}, 32'd0);
        resetn = 1'b1;

        // single pixel
        const_mode = 1'b1; const_colour = 3'd7; mem[10][20] = 3'd0;
        run_scan(10, 20, 0, 0, 0);
        const_mode = 1'b0;
        run_scan(0, 0, 2, 1, 0);
        run_scan(158, 118, 3, 3, 0);
        run_scan(250, 100, 20, 1, 0);
        run_scan(170, 5, 2, 2, 0);
        run_scan(5, 125, 1, 1, 0);

        // unchanged-colour region
        const_mode = 1'b1; const_colour = 3'd5;
        for (int x = 40; x <= 43; x++)
            for (int y = 40; y <= 42; y++)
                mem[x][y] = 3'd5;
        run_scan(40, 40, 3, 2, 0);
        const_mode = 1'b0;

        run_scan(60, 70, 3, 2, 5);
        run_scan(20, 30, 1, 1, 10);

        // reset during WRITE of the second pixel of a 3x1 region
        const_mode = 1'b1; const_colour = 3'd3;
        mem[30][30] = 3'd0; mem[31][30] = 3'd0; mem[32][30] = 3'd0;
        screen_x_min = 8'd30; screen_y_min = 8'd30;
        screen_x_range = 8'd2; screen_y_range = 8'd0;
        screen_start = 1'b1;
        @(negedge clock);
        screen_start = 1'b0;
        for (int c = 1; c < 6; c++) @(negedge clock);
        check_eq("we_before_rst", 32'(fb_we), 32'd1);
        #1 resetn = 1'b0;
        #1;
        check_eq("rst_mid_we", 32'(fb_we), 32'd0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_done", 32'(screen_done), 32'd0);
        check_eq("rst_mid_x", 32'(screen_x), 32'd0);
        got_q.delete();
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (screen_done) dones++;
        end
        check_eq("rst_no_done", 32'(dones), 32'd0);
        check_eq("rst_no_writes", 32'(got_q.size()), 32'd0);
        check_eq("rst_pixel2", 32'(mem[31][30]), 32'd0);
        resetn = 1'b1;
        const_mode = 1'b0;
        run_scan(30, 30, 2, 0, 0);

        for (int i = 0; i < 20; i++) begin
            const_mode   = 1'($urandom_range(0, 3) == 0);
            const_colour = 3'($urandom_range(0, 7));
            run_scan(int'($urandom_range(0, 175)), int'($urandom_range(0, 130)),
                     int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 12)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
